// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types, word-length codes and helpers
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // LCR word-length code to number of data bits (5..8)
  function automatic logic [3:0] wls_bits(input logic [1:0] sl);
    return 4'd5 + {2'b00, sl};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the serial line plus falling-edge detect, idles high
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rxs,
  output logic fall
);

  logic s1, s2, s3;

  // metastability chain, with one extra stage remembering the previous synchronized value
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {s1, s2, s3} <= 3'b111;
    else {s1, s2, s3} <= {rx, s1, s2};

  assign rxs  = s2;
  assign fall = s3 & ~s2;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, 5-8 data bits, optional parity, valid/ready output.
// Define UART_RX_MAJORITY_EN to take each bit decision as a 3-tick majority vote.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SAMPLING_RATE = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  rx,
  input  logic [1:0]            data_bits_sl,
  input  logic                  parity_en,
  input  logic                  parity_even,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int CW = $clog2(SAMPLING_RATE);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] HALF = CW'(SAMPLING_RATE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLING_RATE - 1);

  rx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx, cfg_last;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  cfg_par, cfg_even, par_acc, pe_n, fe_n, commit;
  logic                  rxs, fall, sample, mid;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rxs     (rxs),
    .fall    (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // two previous tick captures, voted together with the current one
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) hist <= 2'b11;
    else if (tick) hist <= {hist[0], rxs};

  assign sample = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = rxs;
`endif

  assign mid  = tick && cnt == LAST;
  assign busy = state != IDLE;

  // frame FSM: tick counting, bit sampling, shift register and per-frame flags
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      cfg_last <= '0;
      cfg_par  <= 1'b0;
      cfg_even <= 1'b0;
      par_acc  <= 1'b0;
      pe_n     <= 1'b0;
      fe_n     <= 1'b0;
      commit   <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (tick && state != IDLE) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (fall) begin
          cnt   <= '0;
          state <= START;
        end
        START: if (tick && cnt == HALF) begin
          if (sample) state <= IDLE;
          else begin
            state    <= DATA;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            pe_n     <= 1'b0;
            cfg_last <= IW'(wls_bits(data_bits_sl) - 4'd1);
            cfg_par  <= parity_en;
            cfg_even <= parity_even;
          end
        end
        DATA: if (mid) begin
          shreg[idx] <= sample;
          par_acc    <= par_acc ^ sample;
          idx        <= idx + 1'b1;
          if (idx == cfg_last) state <= cfg_par ? PARITY : STOP;
        end
        PARITY: if (mid) begin
          pe_n  <= (par_acc ^ sample) == cfg_even;
          state <= STOP;
        end
        STOP: if (mid) begin
          fe_n   <= ~sample;
          commit <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

  // output holding register: load on commit unless a held word is still unconsumed
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (commit && (!rx_valid || rx_ready)) begin
        rx_data    <= shreg;
        parity_err <= pe_n;
        frame_err  <= fe_n;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
      overrun_err <= (commit && rx_valid && !rx_ready) || (overrun_err && !err_clr);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx (honours UART_RX_MAJORITY_EN for the glitch case)
module tb_uart_rx;

  logic       clk, reset_n, tick, rx, parity_en, parity_even, err_clr, rx_ready;
  logic [1:0] data_bits_sl;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, busy;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0, vcnt = 0, v0;

  uart_rx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .rx           (rx),
    .data_bits_sl (data_bits_sl),
    .parity_en    (parity_en),
    .parity_even  (parity_even),
    .err_clr      (err_clr),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running oversampling strobe: one clk high every 4 clks
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted word is popped and compared
  always @(negedge clk) begin
    if (rx_valid) vcnt++;
    if (reset_n && rx_valid && rx_ready) begin
      if (q.size() == 0) chk("unexpected_word", {24'd0, rx_data}, 32'hffff_ffff);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_data", rx_data, e.d);
        chk("sb_parity_err", parity_err, e.pe);
        chk("sb_frame_err", frame_err, e.fe);
      end
    end
  end

  task automatic wait_tick;
    do @(posedge clk); while (!tick);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) wait_tick;
  endtask

  // drives one frame; returns at the negedge right after the stop-sample tick
  task automatic send_frame(input logic [7:0] d, input int n, input logic pen, input logic pbit,
                            input logic stop, input logic glitch);
    rx = 1'b0;
    repeat (16) wait_tick;
    for (int i = 0; i < n; i++) begin
      rx = d[i];
      if (glitch) begin
        repeat (7) wait_tick;
        rx = ~d[i];
        wait_tick;
        rx = d[i];
        repeat (8) wait_tick;
      end else repeat (16) wait_tick;
    end
    if (pen) begin
      rx = pbit;
      repeat (16) wait_tick;
    end
    rx = stop;
    repeat (8) wait_tick;
    rx = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; rx = 1'b1; rx_ready = 1'b1; err_clr = 1'b0;
    data_bits_sl = 2'b11; parity_en = 1'b0; parity_even = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun_err, 0);
    chk("rst_parity", parity_err, 0);
    chk("rst_frame", frame_err, 0);
    reset_n = 1'b1;
    idle(4);
    // 8N1 0x55 with latency and single-cycle valid
    q.push_back('{8'h55, 1'b0, 1'b0});
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_pre_commit", rx_valid, 0);
    @(negedge clk);
    chk("t1_valid", rx_valid, 1);
    chk("t1_data", rx_data, 8'h55);
    @(negedge clk);
    chk("t1_valid_drop", rx_valid, 0);
    idle(4);
    // 7E1 0x41 wrong parity then correct parity
    data_bits_sl = 2'b10; parity_en = 1'b1; parity_even = 1'b1;
    q.push_back('{8'h41, 1'b1, 1'b0});
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    q.push_back('{8'h41, 1'b0, 1'b0});
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    // 8N1 0xA3 with stop bit low
    data_bits_sl = 2'b11; parity_en = 1'b0;
    q.push_back('{8'hA3, 1'b0, 1'b1});
    send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    // false start
    v0 = vcnt;
    rx = 1'b0;
    repeat (4) wait_tick;
    chk("fs_busy", busy, 1);
    idle(12);
    chk("fs_idle", busy, 0);
    chk("fs_no_valid", vcnt - v0, 0);
    // overrun: second frame dropped while first is held
    rx_ready = 1'b0;
    q.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("ov_no_overrun_yet", overrun_err, 0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("ov_held_data", rx_data, 8'h11);
    chk("ov_valid", rx_valid, 1);
    chk("ov_flag", overrun_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ov_cleared", overrun_err, 0);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    // reset during DATA with a word held
    rx_ready = 1'b0;
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    rx = 1'b0;
    repeat (16) wait_tick;
    rx = 1'b1;
    repeat (16) wait_tick;
    rx = 1'b0;
    repeat (16) wait_tick;
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_busy", busy, 0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rx_ready = 1'b1;
    idle(4);
    q.push_back('{8'h7E, 1'b0, 1'b0});
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    // one-tick inverted glitch on every data mid-bit tick
`ifdef UART_RX_MAJORITY_EN
    q.push_back('{8'hF0, 1'b0, 1'b0});
`else
    q.push_back('{8'h0F, 1'b0, 1'b0});
`endif
    send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
